// File: rtl/mcb_port_arbiter_if.sv
// Bundle of signals between the clients, the arbiter and one MCB user port.
//   slave  : arbiter view (client requests and MCB FIFO flags in; grants,
//            responses and MCB pushes/pops out).
//   master : the opposite view, for whatever drives the clients and models the MCB.
// Client i occupies slice i of the packed req_addr / req_wdata / req_mask vectors.
interface mcb_port_arbiter_if #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned DATA_WIDTH  = 32
);
  localparam int unsigned MaskWidth = DATA_WIDTH / 8;

  logic                              calib_done;
  // Client side
  logic [NUM_CLIENTS-1:0]            req_valid;
  logic [NUM_CLIENTS-1:0]            req_ready;
  logic [NUM_CLIENTS-1:0]            req_write;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_CLIENTS*MaskWidth-1:0]  req_mask;
  logic [NUM_CLIENTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]             rsp_rdata;
  logic                              rsp_error;
  logic                              err_sticky;
  // MCB user port side
  logic                              cmd_en;
  logic [2:0]                        cmd_instr;
  logic [5:0]                        cmd_bl;
  logic [ADDR_WIDTH-1:0]             cmd_byte_addr;
  logic                              cmd_full;
  logic                              wr_en;
  logic [MaskWidth-1:0]              wr_mask;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic                              wr_full;
  logic                              rd_en;
  logic [DATA_WIDTH-1:0]             rd_data;
  logic                              rd_empty;

  modport slave (
    input  calib_done, req_valid, req_write, req_addr, req_wdata, req_mask,
           cmd_full, wr_full, rd_data, rd_empty,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, err_sticky,
           cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en
  );

  modport master (
    output calib_done, req_valid, req_write, req_addr, req_wdata, req_mask,
           cmd_full, wr_full, rd_data, rd_empty,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, err_sticky,
           cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en
  );
endinterface

// File: rtl/mcb_port_arbiter.sv
// Round-robin front-end for one MCB user port. Clients issue single-word reads
// and writes; one request is outstanding at a time and completes with a one-cycle
// rsp_valid pulse to its owner. Reads that see no data for TIMEOUT_CYCLES wait
// cycles complete with rsp_error and set err_sticky.
// Ports:
//   clk  - system clock (also the MCB cmd/wr/rd FIFO clock)
//   rst  - asynchronous active-high reset
//   bus  - client request/response and MCB cmd/wr/rd FIFO signals (slave view)
module mcb_port_arbiter #(
  parameter int unsigned NUM_CLIENTS    = 2,
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst,
  mcb_port_arbiter_if.slave bus
);
  localparam int unsigned MaskWidth = DATA_WIDTH / 8;
  localparam int unsigned IdxW      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned CntW      = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned LowBits   = $clog2(MaskWidth);

  typedef enum logic [2:0] {StIdle, StWrData, StWrCmd, StRdCmd, StRdWait} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        last_grant_q, grant_q, gnt_idx;
  logic                   gnt_found, grant_valid;
  logic                   write_q;
  logic [ADDR_WIDTH-1:0]  addr_q, sel_addr;
  logic [DATA_WIDTH-1:0]  wdata_q, sel_wdata;
  logic [MaskWidth-1:0]   mask_q, sel_mask;
  logic [CntW-1:0]        cnt_q;
  logic [NUM_CLIENTS-1:0] rsp_valid_q, owner_onehot;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_error_q, err_sticky_q;

  // Rotating priority: first valid client above last_grant, else first valid overall.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (!gnt_found && bus.req_valid[i] && (IdxW'(i) > last_grant_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (!gnt_found && bus.req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(i);
      end
    end
  end

  assign grant_valid = (state_q == StIdle) && bus.calib_done && gnt_found && !rst;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_idx == IdxW'(i)) begin
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_mask  = bus.req_mask[i*MaskWidth +: MaskWidth];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_valid) bus.req_ready[gnt_idx] = 1'b1;
    owner_onehot = '0;
    owner_onehot[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NUM_CLIENTS - 1);
      grant_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            grant_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            write_q      <= bus.req_write[gnt_idx];
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            mask_q       <= sel_mask;
            state_q      <= bus.req_write[gnt_idx] ? StWrData : StRdCmd;
          end
        end
        StWrData: if (!bus.wr_full) state_q <= StWrCmd;
        StWrCmd: begin
          if (!bus.cmd_full) begin
            rsp_valid_q <= owner_onehot;
            state_q     <= StIdle;
          end
        end
        StRdCmd: begin
          if (!bus.cmd_full) begin
            cnt_q   <= '0;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          // Data present on the final wait cycle still counts as success.
          if (!bus.rd_empty) begin
            rsp_rdata_q <= bus.rd_data;
            rsp_valid_q <= owner_onehot;
            state_q     <= StIdle;
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b1;
            err_sticky_q <= 1'b1;
            rsp_valid_q  <= owner_onehot;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO strobes stay combinational so a flag drop is used the same cycle.
  assign bus.cmd_en        = ((state_q == StWrCmd) || (state_q == StRdCmd)) && !bus.cmd_full;
  assign bus.cmd_instr     = (state_q == StRdCmd) ? 3'b001 : 3'b000;
  assign bus.cmd_bl        = 6'd0;
  assign bus.cmd_byte_addr = {addr_q[ADDR_WIDTH-1:LowBits], {LowBits{1'b0}}};
  assign bus.wr_en         = (state_q == StWrData) && !bus.wr_full;
  assign bus.wr_data       = wdata_q;
  assign bus.wr_mask       = mask_q;
  assign bus.rd_en         = (state_q == StRdWait) && !bus.rd_empty;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_error     = rsp_error_q;
  assign bus.err_sticky    = err_sticky_q;

  logic unused_write;
  assign unused_write = write_q;
endmodule

// File: doc/mcb_port_arbiter.md
Name: mcb_port_arbiter

Overview:
Parametrised N-client front-end for one LPDDR MCB user port (cmd/wr/rd FIFOs of s6_lpddr_ram). Replaces direct tie-off of the port signals in the top level. Clients issue single-word read/write requests through a valid/ready handshake. A round-robin arbiter serialises them onto the port and returns read data or write acks per client, with a read-timeout error path.

Parameters:
NUM_CLIENTS, 2, number of client channels (1..8)
ADDR_WIDTH, 30, byte address width, matches MCB cmd_byte_addr
DATA_WIDTH, 32, port data width (32, 64 or 128); MASK_WIDTH = DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, max cycles waiting for read data (>=2)

Ports:
clk  in  1  system clock, also drives MCB cmd/wr/rd clocks
rst  in  1  asynchronous, active-high reset
calib_done  in  1  MCB calibration complete
req_valid  in  NUM_CLIENTS  per-client request valid
req_ready  out  NUM_CLIENTS  per-client request accepted (one-hot or zero)
req_write  in  NUM_CLIENTS  1=write, 0=read
req_addr  in  NUM_CLIENTS*ADDR_WIDTH  byte addresses, client i at slice i
req_wdata  in  NUM_CLIENTS*DATA_WIDTH  write data
req_mask  in  NUM_CLIENTS*MASK_WIDTH  write byte mask, 1=byte NOT written (MCB sense)
rsp_valid  out  NUM_CLIENTS  one-cycle completion pulse to owning client
rsp_rdata  out  DATA_WIDTH  read data, shared, valid with rsp_valid
rsp_error  out  1  qualifies rsp_valid: read timed out
err_sticky  out  1  set on any timeout, cleared only by rst
cmd_en  out  1  MCB cmd push
cmd_instr  out  3  000 write, 001 read
cmd_bl  out  6  burst length-1, always 0
cmd_byte_addr  out  ADDR_WIDTH  latched address, low log2(MASK_WIDTH) bits forced 0
cmd_full  in  1  MCB cmd FIFO full
wr_en  out  1  MCB write-data push
wr_mask  out  MASK_WIDTH  latched mask
wr_data  out  DATA_WIDTH  latched data
wr_full  in  1  MCB write FIFO full
rd_en  out  1  MCB read-data pop
rd_data  in  DATA_WIDTH  MCB read data
rd_empty  in  1  MCB read FIFO empty

Behaviour:
- Reset: state IDLE, last_grant=NUM_CLIENTS-1, all outputs 0, err_sticky=0, timeout counter 0. Reset mid-operation abandons the request; no rsp_valid is issued.
- States: IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT.
- IDLE: if calib_done and any req_valid, grant first valid client scanning from (last_grant+1) mod N upward with wrap. req_ready[g]=1 combinationally that cycle. At the handshake, latch write, addr, wdata and mask, set last_grant=g, and go to WR_DATA (write) or RD_CMD (read). With calib_done=0, req_ready=0.
- WR_DATA: wr_en=!wr_full. When wr_en=1, go to WR_CMD.
- WR_CMD: cmd_en=!cmd_full, instr=000. When cmd_en=1, go to IDLE and register rsp_valid[g]=1 for the next cycle, with rsp_error=0.
- RD_CMD: cmd_en=!cmd_full, instr=001. When cmd_en=1, clear the counter and go to RD_WAIT.
- RD_WAIT: rd_en=!rd_empty. On rd_en, register rsp_rdata=rd_data and pulse rsp_valid[g] next cycle, then go to IDLE.
  - Counter increments each cycle with rd_empty=1. At TIMEOUT_CYCLES-1 without data: go to IDLE, pulse rsp_valid[g] with rsp_error=1 and rsp_rdata=0, and set err_sticky.
  - Data arriving on the timeout cycle wins; it is treated as a success.
- Outputs cmd_en, wr_en and rd_en are combinational from state and FIFO flags. They are never asserted while the matching full/empty flag blocks them.
- cmd_bl, cmd_byte_addr, wr_data and wr_mask are stable from grant until return to IDLE.
- Minimum latency with no backpressure, handshake at cycle T:
  - write: wr_en T+1, cmd_en T+2, rsp_valid T+3.
  - read: cmd_en T+1, rd_en at the first non-empty cycle R>=T+2, rsp_valid R+1.
- A new grant is possible in the same cycle rsp_valid is high (IDLE reached). One request is outstanding at a time.
- rsp_rdata holds its last value between responses. rsp_valid is at most one-hot.
- A client dropping req_valid before ready is legal; it is simply not granted.

Test Plan:
- Reset, calib_done=0, req_valid=01 -> req_ready stays 00. Raise calib_done -> req_ready=01 the same cycle; all MCB enables 0 until the grant.
- Client0 write addr 0x00000013, data 0xDEADBEEF, mask 0x0, no backpressure -> wr_en T+1 with data 0xDEADBEEF; cmd_en T+2 with instr 000, addr 0x10, bl 0; rsp_valid=01 at T+3.
- Client1 read addr 0x40, rd_empty held 1 for 5 cycles then rd_data=0x12345678 -> single rd_en; rsp_valid=10, rsp_rdata=0x12345678, rsp_error=0.
- NUM_CLIENTS=3, all valid continuously (reads, immediate data) -> grant order 0,1,2,0,1,2; no client granted twice in a row.
- wr_full=1 for 4 cycles then cmd_full=1 for 3 cycles -> wr_en and cmd_en each asserted exactly once, only after their flag drops.
- TIMEOUT_CYCLES=8, read with rd_empty stuck 1 -> after 8 wait cycles rsp_valid with rsp_error=1, rsp_rdata=0, err_sticky=1. Assert rst mid-read -> all outputs 0 and no rsp_valid.
